// File: rtl/fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit_if : PC-register, branch, decode and imem signals of     |
// |                 the instruction-fetch controller                    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface fetch_unit_if #(
  parameter int BITS = 32
);
  logic [BITS-1:0] pcCur;
  logic [BITS-1:0] pcNext;
  logic            stallPC;
  logic            branchTaken;
  logic [BITS-1:0] branchTarget;
  logic            hazardStall;
  logic            imemReq;
  logic [BITS-1:0] imemAddr;
  logic [BITS-1:0] imemRdata;
  logic            imemValid;
  logic [BITS-1:0] instrOut;
  logic [BITS-1:0] pcOutID;
  logic            instrValid;
  logic            imemErr;

  // master: the fetch controller itself
  modport master (
    input  pcCur, branchTaken, branchTarget, hazardStall, imemRdata, imemValid,
    output pcNext, stallPC, imemReq, imemAddr, instrOut, pcOutID, instrValid, imemErr
  );

  // slave: PC register, execute, decode and instruction memory
  modport slave (
    output pcCur, branchTaken, branchTarget, hazardStall, imemRdata, imemValid,
    input  pcNext, stallPC, imemReq, imemAddr, instrOut, pcOutID, instrValid, imemErr
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : single-outstanding instruction fetch into IF/ID with  |
// |              branch flush, skid hold and sticky memory timeout     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_unit #(
  parameter int BITS    = 32,
  parameter int TIMEOUT = 64,
  parameter int PC_STEP = 4
) (
  input wire CLK,
  input wire RESET,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [BITS-1:0] STEP    = BITS'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] req_addr_q, req_addr_d;
  logic            imem_req_q, imem_req_d;
  logic [BITS-1:0] imem_addr_q, imem_addr_d;
  logic [BITS-1:0] instr_q, instr_d;
  logic [BITS-1:0] pc_id_q, pc_id_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            flush_q, flush_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] skid_q, skid_d;

  logic            load;
  logic [BITS-1:0] load_data;
  logic            if_free;
  logic [BITS-1:0] pc_next;
  logic            stall_pc;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    instr_d     = instr_q;
    pc_id_d     = pc_id_q;
    valid_d     = valid_q;
    err_d       = err_q;
    flush_d     = flush_q;
    cnt_d       = cnt_q;
    skid_d      = skid_q;
    load        = 1'b0;
    load_data   = skid_q;
    if_free     = !valid_q || !bus.hazardStall;

    case (state_q)
      S_IDLE: begin
        state_d     = S_WAIT;
        req_addr_d  = bus.pcCur;
        imem_req_d  = 1'b1;
        imem_addr_d = bus.pcCur;
        cnt_d       = '0;
        flush_d     = 1'b0;
      end
      S_WAIT: begin
        if (cnt_q == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (bus.branchTaken) begin
          // A response landing with the branch is simply dropped.
          if (bus.imemValid) begin
            state_d    = S_IDLE;
            imem_req_d = 1'b0;
            flush_d    = 1'b0;
          end else begin
            flush_d = 1'b1;
          end
        end else if (bus.imemValid) begin
          imem_req_d = 1'b0;
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = S_IDLE;
          end else if (if_free) begin
            load      = 1'b1;
            load_data = bus.imemRdata;
            state_d   = S_IDLE;
          end else begin
            skid_d  = bus.imemRdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.branchTaken) begin
          state_d = S_IDLE;
        end else if (!bus.hazardStall) begin
          load      = 1'b1;
          load_data = skid_q;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        imem_req_d = 1'b0;
      end
    endcase

    if (bus.branchTaken) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = load_data;
      pc_id_d = req_addr_q;
      valid_d = 1'b1;
    end else if (valid_q && !bus.hazardStall) begin
      valid_d = 1'b0;
    end

    // The PC moves only on a redirect or when a word enters IF/ID.
    if (bus.branchTaken) begin
      stall_pc = 1'b0;
      pc_next  = bus.branchTarget;
    end else if (load) begin
      stall_pc = 1'b0;
      pc_next  = req_addr_q + STEP;
    end else begin
      stall_pc = 1'b1;
      pc_next  = bus.pcCur;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      instr_q     <= '0;
      pc_id_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      flush_q     <= 1'b0;
      cnt_q       <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      pc_id_q     <= pc_id_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      flush_q     <= flush_d;
      cnt_q       <= cnt_d;
      skid_q      <= skid_d;
    end
  end

  assign bus.pcNext     = pc_next;
  assign bus.stallPC    = stall_pc;
  assign bus.imemReq    = imem_req_q;
  assign bus.imemAddr   = imem_addr_q;
  assign bus.instrOut   = instr_q;
  assign bus.pcOutID    = pc_id_q;
  assign bus.instrValid = valid_q;
  assign bus.imemErr    = err_q;
endmodule
`default_nettype wire
